game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/pong_pkg.sv | 19 +
 rtl/bar_pos_latch.sv | 37 +++
 rtl/game_sequencer.sv | 126 ++++++++++++
 tb/tb_game_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, opcodes, o_result field offsets and screen defaults
// for game_sequencer and bar_pos_latch.
package pong_pkg;
    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;
    localparam logic [1:0] OP_BAR_WRITE = 2'b00;
    localparam logic [1:0] OP_START     = 2'b01;
    localparam logic [1:0] OP_PAUSE     = 2'b10;
    localparam logic [1:0] OP_NOP       = 2'b11;
    localparam int RES_P1_LSB    = 0;
    localparam int RES_P2_LSB    = 4;
    localparam int RES_STATE_LSB = 8;
    localparam int Y_MAX_DEF     = 479;
endpackage

// File: rtl/bar_pos_latch.sv
// bar_pos_latch: one paddle's clamped pending position, frame-synchronous commit
// and one-cycle refresh pulse.
module bar_pos_latch import pong_pkg::*; #(
    parameter int Y_MAX = Y_MAX_DEF,
    parameter int BAR_H = 60
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_wr,
    input  logic [8:0] i_y,
    input  logic       i_commit,
    output logic [8:0] o_y,
    output logic       o_refresh
);
    localparam logic [8:0] Y_LIM = 9'(Y_MAX - BAR_H);
    localparam logic [8:0] Y_RST = 9'((Y_MAX + 1 - BAR_H) / 2);
    logic [8:0] r_pend, r_y;
    logic       r_valid, r_refresh, w_fire;
    assign w_fire    = i_commit && r_valid;
    assign o_y       = r_y;
    assign o_refresh = r_refresh;
    // A write landing on the commit edge commits the old value and stays pending.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend    <= '0;
            r_valid   <= 1'b0;
            r_y       <= Y_RST;
            r_refresh <= 1'b0;
        end else begin
            r_refresh <= w_fire;
            if (w_fire) r_y <= r_pend;
            if (i_wr) r_pend <= (i_y > Y_LIM) ? Y_LIM : i_y;
            r_valid <= i_wr || (r_valid && !w_fire && !i_clr);
        end
    end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: pong match controller driven by custom instructions and frame pulses.
// Define GAME_SEQUENCER_PAUSE_EN to build in the PAUSE state and opcode.
module game_sequencer import pong_pkg::*; #(
    parameter int WIN_SCORE    = 3,
    parameter int BAR_H        = 60,
    parameter int Y_MAX        = Y_MAX_DEF,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ci_valid,
    input  logic [31:0] i_ci_data,
    input  logic        i_frame_end,
    input  logic        i_point_p1,
    input  logic        i_point_p2,
    output logic        o_ci_done,
    output logic [31:0] o_result,
    output logic        o_enable_pong,
    output logic [8:0]  o_bar1_y,
    output logic [8:0]  o_bar2_y,
    output logic        o_refresh_bar1,
    output logic        o_refresh_bar2,
    output logic        o_ball_serve
);
    localparam int CW = $clog2(SERVE_FRAMES + 1);
    state_t        r_state, w_state;
    logic [3:0]    r_p1, r_p2, w_p1, w_p2;
    logic [CW-1:0] r_frames, w_frames;
    logic          r_ci_done, r_ball_serve, w_ball_serve;
    logic          w_start, w_bar_wr, w_live, w_commit, w_unused;
    logic [1:0]    w_op;
    logic [31:0]   w_result;

    assign w_op     = i_ci_data[11:10];
    assign w_live   = r_state == ST_SERVE || r_state == ST_PLAY;
    assign w_start  = i_ci_valid && w_op == OP_START && (r_state == ST_MENU || r_state == ST_OVER);
    assign w_bar_wr = i_ci_valid && w_op == OP_BAR_WRITE && r_state != ST_MENU && r_state != ST_OVER;
    assign w_commit = i_frame_end && w_live;
    assign w_unused = &{1'b0, i_ci_data[31:12]};
`ifdef GAME_SEQUENCER_PAUSE_EN
    logic w_pause;
    assign w_pause = i_ci_valid && w_op == OP_PAUSE;
`endif

    // A point in the same cycle as a PAUSE command wins; the pause is dropped.
    always_comb begin
        w_state      = r_state;
        w_p1         = r_p1;
        w_p2         = r_p2;
        w_frames     = '0;
        w_ball_serve = 1'b0;
        case (r_state)
            ST_MENU, ST_OVER: begin
                if (w_start) begin
                    w_state = ST_SERVE;
                    w_p1    = '0;
                    w_p2    = '0;
                end
            end
            ST_SERVE: begin
                if (!i_frame_end) w_frames = r_frames;
                else if (r_frames == CW'(SERVE_FRAMES - 1)) begin
                    w_state      = ST_PLAY;
                    w_ball_serve = 1'b1;
                end else w_frames = r_frames + CW'(1);
            end
            ST_PLAY: begin
                if (i_point_p1) begin
                    w_p1    = r_p1 + 4'd1;
                    w_state = (r_p1 == 4'(WIN_SCORE - 1)) ? ST_OVER : ST_SERVE;
                end else if (i_point_p2) begin
                    w_p2    = r_p2 + 4'd1;
                    w_state = (r_p2 == 4'(WIN_SCORE - 1)) ? ST_OVER : ST_SERVE;
                end
`ifdef GAME_SEQUENCER_PAUSE_EN
                else if (w_pause) w_state = ST_PAUSE;
`endif
            end
`ifdef GAME_SEQUENCER_PAUSE_EN
            ST_PAUSE: if (w_pause) w_state = ST_PLAY;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_MENU;
            r_p1         <= '0;
            r_p2         <= '0;
            r_frames     <= '0;
            r_ci_done    <= 1'b0;
            r_ball_serve <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_p1         <= w_p1;
            r_p2         <= w_p2;
            r_frames     <= w_frames;
            r_ci_done    <= i_ci_valid;
            r_ball_serve <= w_ball_serve;
        end
    end

    always_comb begin
        w_result = '0;
        w_result[RES_P1_LSB +: 4]    = r_p1;
        w_result[RES_P2_LSB +: 4]    = r_p2;
        w_result[RES_STATE_LSB +: 3] = r_state;
    end

    assign o_result      = w_result;
    assign o_ci_done     = r_ci_done;
    assign o_ball_serve  = r_ball_serve;
    assign o_enable_pong = w_live;

    bar_pos_latch #(.Y_MAX(Y_MAX), .BAR_H(BAR_H)) u_bar1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_start),
        .i_wr(w_bar_wr && !i_ci_data[9]), .i_y(i_ci_data[8:0]), .i_commit(w_commit),
        .o_y(o_bar1_y), .o_refresh(o_refresh_bar1)
    );
    bar_pos_latch #(.Y_MAX(Y_MAX), .BAR_H(BAR_H)) u_bar2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_start),
        .i_wr(w_bar_wr && i_ci_data[9]), .i_y(i_ci_data[8:0]), .i_commit(w_commit),
        .o_y(o_bar2_y), .o_refresh(o_refresh_bar2)
    );
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed and random stimulus checked every cycle against a
// behavioural match model, plus literal checks of the headline scenarios.
module tb_game_sequencer;
    localparam int WIN_SCORE = 3, BAR_H = 60, Y_MAX = 479, SERVE_FRAMES = 60;
`ifdef GAME_SEQUENCER_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif
    logic        i_clk = 0, i_rst = 0, i_ci_valid = 0, i_frame_end = 0, i_point_p1 = 0, i_point_p2 = 0;
    logic [31:0] i_ci_data = '0;
    logic        o_ci_done, o_enable_pong, o_refresh_bar1, o_refresh_bar2, o_ball_serve;
    logic [31:0] o_result;
    logic [8:0]  o_bar1_y, o_bar2_y;
    int errors = 0, checks = 0;
    int n_serve = 0, n_ref1 = 0, n_ref2 = 0;
    bit cmp_en = 0;
    int m_st, m_p1, m_p2, m_frames;
    int m_pv[2], m_py[2], m_y[2];
    bit m_done, m_serve;
    bit m_ref[2];

    game_sequencer dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ci_valid(i_ci_valid), .i_ci_data(i_ci_data),
        .i_frame_end(i_frame_end), .i_point_p1(i_point_p1), .i_point_p2(i_point_p2),
        .o_ci_done(o_ci_done), .o_result(o_result), .o_enable_pong(o_enable_pong),
        .o_bar1_y(o_bar1_y), .o_bar2_y(o_bar2_y), .o_refresh_bar1(o_refresh_bar1),
        .o_refresh_bar2(o_refresh_bar2), .o_ball_serve(o_ball_serve)
    );

    always #5 i_clk = ~i_clk;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_st = 0; m_p1 = 0; m_p2 = 0; m_frames = 0;
        m_pv = '{0, 0}; m_py = '{0, 0};
        m_y = '{(Y_MAX + 1 - BAR_H) / 2, (Y_MAX + 1 - BAR_H) / 2};
        m_done = 0; m_serve = 0; m_ref = '{0, 0};
    endfunction

    // Match rules applied to one clock edge's worth of inputs.
    function automatic void model_step();
        int op, b, y;
        bit live, cmd_pause;
        op = int'(i_ci_data[11:10]);
        b = int'(i_ci_data[9]);
        y = int'(i_ci_data[8:0]);
        live = (m_st == 1 || m_st == 2);
        cmd_pause = PAUSE_EN && i_ci_valid && op == 2;
        m_done = i_ci_valid;
        m_serve = 0;
        m_ref = '{0, 0};
        for (int k = 0; k < 2; k++)
            if (i_frame_end && live && m_pv[k] != 0) begin
                m_y[k] = m_py[k]; m_ref[k] = 1; m_pv[k] = 0;
            end
        if (i_ci_valid && op == 0 && m_st != 0 && m_st != 4) begin
            m_py[b] = (y > Y_MAX - BAR_H) ? Y_MAX - BAR_H : y;
            m_pv[b] = 1;
        end
        if (m_st == 0 || m_st == 4) begin
            if (i_ci_valid && op == 1) begin
                m_st = 1; m_p1 = 0; m_p2 = 0; m_pv = '{0, 0}; m_frames = 0;
            end
        end else if (m_st == 1) begin
            if (i_frame_end) begin
                m_frames++;
                if (m_frames == SERVE_FRAMES) begin m_st = 2; m_serve = 1; end
            end
        end else if (m_st == 2) begin
            if (i_point_p1) begin
                m_p1++; m_st = (m_p1 == WIN_SCORE) ? 4 : 1; m_frames = 0;
            end else if (i_point_p2) begin
                m_p2++; m_st = (m_p2 == WIN_SCORE) ? 4 : 1; m_frames = 0;
            end else if (cmd_pause) m_st = 3;
        end else if (cmd_pause) m_st = 2;
    endfunction

    always @(negedge i_clk) if (cmp_en && !i_rst) begin
        check("ci_done", o_ci_done, m_done);
        check("result", o_result, m_st * 256 + m_p2 * 16 + m_p1);
        check("enable_pong", o_enable_pong, m_st == 1 || m_st == 2);
        check("bar1_y", o_bar1_y, m_y[0]);
        check("bar2_y", o_bar2_y, m_y[1]);
        check("refresh_bar1", o_refresh_bar1, m_ref[0]);
        check("refresh_bar2", o_refresh_bar2, m_ref[1]);
        check("ball_serve", o_ball_serve, m_serve);
    end

    always @(negedge i_clk) begin
        if (o_ball_serve) n_serve++;
        if (o_refresh_bar1) n_ref1++;
        if (o_refresh_bar2) n_ref2++;
    end

    task automatic cyc(bit v, bit [1:0] op, bit b, int y, bit fe, bit a, bit c);
        i_ci_valid = v; i_ci_data = {20'b0, op, b, 9'(y)};
        i_frame_end = fe; i_point_p1 = a; i_point_p2 = c;
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cyc(0, 2'b11, 0, 0, 0, 0, 0);
    endtask

    task automatic serve_out();
        for (int k = 0; k < SERVE_FRAMES; k++) begin
            cyc(0, 2'b11, 0, 0, 1, 0, 0);
            idle(1);
        end
    endtask

    // Asynchronous reset asserted mid-cycle, optionally with a coincident START strobe.
    task automatic do_reset(bit strobe);
        i_ci_valid = strobe; i_ci_data = 32'h0000_0400;
        i_frame_end = 0; i_point_p1 = 0; i_point_p2 = 0;
        #2 i_rst = 1;
        #1;
        model_reset();
        check("rst_result", o_result, 0);
        check("rst_bar1_y", o_bar1_y, 210);
        check("rst_bar2_y", o_bar2_y, 210);
        check("rst_enable", o_enable_pong, 0);
        check("rst_done", o_ci_done, 0);
        check("rst_refresh", o_refresh_bar1 | o_refresh_bar2, 0);
        check("rst_serve", o_ball_serve, 0);
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
        i_ci_valid = 0;
        i_rst = 0;
    endtask

    initial begin
        int r1, r2;
        model_reset();
        do_reset(0);
        cmp_en = 1;
        cyc(1, 2'b01, 0, 0, 0, 0, 0);
        check("start_state", o_result[10:8], 1);
        serve_out();
        check("serve_count", n_serve, 1);
        check("play_state", o_result[10:8], 2);
        check("play_enable", o_enable_pong, 1);
        r1 = n_ref1;
        cyc(1, 2'b00, 0, 470, 0, 0, 0);
        check("write_done", o_ci_done, 1);
        cyc(0, 2'b11, 0, 0, 1, 0, 0);
        check("clamp_bar1", o_bar1_y, 419);
        idle(3);
        check("refresh1_once", n_ref1 - r1, 1);
        r2 = n_ref2;
        cyc(1, 2'b00, 1, 100, 0, 0, 0);
        cyc(1, 2'b00, 1, 200, 0, 0, 0);
        cyc(0, 2'b11, 0, 0, 1, 0, 0);
        idle(3);
        check("last_write_bar2", o_bar2_y, 200);
        check("refresh2_once", n_ref2 - r2, 1);
        cyc(1, 2'b10, 0, 0, 0, 0, 0);
        cyc(1, 2'b00, 0, 50, 0, 0, 0);
        cyc(0, 2'b11, 0, 0, 1, 0, 0);
        idle(1);
        check("pause_state", o_result[10:8], PAUSE_EN ? 3 : 2);
        check("pause_hold", o_bar1_y, PAUSE_EN ? 419 : 50);
        cyc(1, 2'b10, 0, 0, 0, 0, 0);
        cyc(0, 2'b11, 0, 0, 1, 0, 0);
        check("resume_commit", o_bar1_y, 50);
        check("resume_state", o_result[10:8], 2);
        cyc(0, 2'b11, 0, 0, 0, 1, 1);
        check("both_points", o_result[7:0], 8'h01);
        check("both_state", o_result[10:8], 1);
        for (int p = 0; p < 2; p++) begin
            serve_out();
            cyc(0, 2'b11, 0, 0, 0, 1, 0);
        end
        check("win_score", o_result[3:0], 3);
        check("win_state", o_result[10:8], 4);
        check("win_enable", o_enable_pong, 0);
        cyc(1, 2'b00, 0, 5, 1, 0, 0);
        check("over_no_write", o_bar1_y, 50);
        cyc(1, 2'b01, 0, 0, 0, 0, 0);
        check("restart_result", o_result, 32'h100);
        cyc(0, 2'b11, 0, 0, 1, 0, 0);
        cyc(1, 2'b00, 0, 300, 0, 0, 0);
        cyc(1, 2'b00, 1, 10, 0, 0, 0);
        r1 = n_ref1; r2 = n_ref2;
        do_reset(1);
        idle(1);
        check("rst_done_after", o_ci_done, 0);
        for (int k = 0; k < 4; k++) cyc(0, 2'b11, 0, 0, 1, 0, 0);
        check("rst_no_refresh", (n_ref1 - r1) + (n_ref2 - r2), 0);
        for (int k = 0; k < 6000; k++) begin
            bit v, fe, a, c;
            bit [1:0] op;
            if ($urandom_range(0, 1999) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
                continue;
            end
            v = $urandom_range(0, 3) == 0;
            op = 2'($urandom_range(0, 3));
            if ((m_st == 0 || m_st == 4) && $urandom_range(0, 3) == 0) begin v = 1; op = 2'b01; end
            fe = $urandom_range(0, 2) == 0;
            a = $urandom_range(0, 14) == 0;
            c = $urandom_range(0, 14) == 0;
            cyc(v, op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 511)), fe, a, c);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
